wbm_ctrl: RTL and testbench
===========================

WBM_CTRL -- requirements
Module: wbm_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of cycles stb is held waiting for ack (legal range 2..255).
REQ-002 SHALL have port wb_clk_i  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have port wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port cmd_valid  in  1  command request.
REQ-005 SHALL have port cmd_ready  out  1  command accepted when valid&ready.
REQ-006 SHALL have port cmd_we  in  1  1=write, 0=read.
REQ-007 SHALL have port cmd_wide  in  1  1=64-bit access as two 32-bit beats, 0=one 32-bit beat.
REQ-008 SHALL have port cmd_adr  in  32  byte address; bits [2:0] forced 0 when wide, bits [1:0] forced 0 when narrow.
REQ-009 SHALL have port cmd_wdata  in  64  write data; narrow uses [31:0].
REQ-010 SHALL have port rsp_valid  out  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_err  out  1  completion was a timeout, valid with rsp_valid.
REQ-012 SHALL have port rsp_rdata  out  64  read data; narrow fills [31:0], [63:32]=0.
REQ-013 SHALL have ports wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone initiator controls.
REQ-014 SHALL have ports wbm_sel_o  out  4, wbm_adr_o  out  32, wbm_dat_o  out  32.
REQ-015 SHALL have ports wbm_ack_i  in  1, wbm_dat_i  in  32.

Function
REQ-016 SHALL implement states IDLE, LO, GAP, HI, RESP; cmd_ready=1 only in IDLE.
REQ-017 On handshake in IDLE SHALL register we/wide/adr/wdata and go to LO; all Wishbone outputs are registered.
REQ-018 In LO SHALL drive cyc=stb=1, sel=4'hF, we=cmd_we, adr=aligned base, dat_o=wdata[31:0].
REQ-019 In HI SHALL drive same as LO but adr=base+4, dat_o=wdata[63:32] (low word always precedes high word).
REQ-020 On ack sampled in LO: narrow -> RESP; wide -> GAP; on read, wbm_dat_i captured into rsp_rdata[31:0].
REQ-021 On ack sampled in HI -> RESP; on read, wbm_dat_i captured into rsp_rdata[63:32].
REQ-022 Cycle after ack, cyc and stb SHALL be 0; GAP lasts exactly 1 cycle with cyc=stb=0, then HI.
REQ-023 RESP SHALL last 1 cycle with rsp_valid=1, then IDLE; rsp_rdata held until next handshake.
REQ-024 Timeout counter SHALL clear on entering LO/HI and count each stb-high cycle without ack; after TIMEOUT_CYCLES such cycles, stb/cyc drop and FSM goes to RESP with rsp_err=1, skipping any remaining beat.
REQ-025 Ack on the same cycle the count reaches TIMEOUT_CYCLES SHALL win (normal completion, rsp_err=0).
REQ-026 wbm_ack_i in IDLE, GAP or RESP SHALL be ignored; cmd_valid outside IDLE SHALL be ignored (not queued).
REQ-027 rsp_err SHALL be 0 whenever rsp_valid=0; rsp_rdata on write completion SHALL be unchanged from prior value.
REQ-028 Latency with 1-cycle responder (ack one cycle after stb): narrow handshake N -> stb N+1, ack N+2, rsp_valid N+3, cmd_ready N+4; wide rsp_valid N+6.

Reset
REQ-029 Reset SHALL immediately force IDLE, cmd_ready=1 after release, cyc=stb=we=0, sel=0, adr=0, dat_o=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, counter=0.
REQ-030 Reset mid-transaction SHALL drop cyc/stb asynchronously and discard the command with no rsp_valid.

Verification
REQ-031 Narrow write adr=32'h3000_0004 data=1, responder acks 1 cycle after stb -> one beat adr 3000_0004 dat 1 we=1, rsp_valid at N+3, rsp_err=0.
REQ-032 Wide write adr=32'h3001_0018 wdata=64'h0000_00AB_1234_5678 -> beat1 adr 3001_0018 dat 1234_5678, gap cycle stb=0, beat2 adr 3001_001C dat 0000_00AB.
REQ-033 Wide read adr=32'h3003_0008, responder returns DEAD_BEEF then 0000_CAFE -> rsp_rdata=64'h0000_CAFE_DEAD_BEEF, rsp_err=0.
REQ-034 Narrow read, responder never acks, TIMEOUT_CYCLES=16 -> stb high exactly 16 cycles, then rsp_valid=1 rsp_err=1; wide read timing out in LO issues no HI beat.
REQ-035 Assert wb_rst_i while stb high in HI -> cyc/stb 0 same cycle, no rsp_valid, next command runs normally from LO.
REQ-036 cmd_valid held high continuously with spurious ack in GAP -> commands accepted only in IDLE, spurious ack does not advance FSM or capture data.

Source files
------------

// File: rtl/wbm_ctrl_if.sv
// Command/response and Wishbone initiator signal bundle for wbm_ctrl.
// The master modport is the controller's view; the slave modport is the
// view of whatever issues commands and models the Wishbone target.
interface wbm_ctrl_if;
    // command side
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic        cmd_wide;
    logic [31:0] cmd_adr;
    logic [63:0] cmd_wdata;
    // response side
    logic        rsp_valid;
    logic        rsp_err;
    logic [63:0] rsp_rdata;
    // Wishbone initiator
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_wide, cmd_adr, cmd_wdata,
        input  wbm_ack_i, wbm_dat_i,
        output cmd_ready, rsp_valid, rsp_err, rsp_rdata,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_wide, cmd_adr, cmd_wdata,
        output wbm_ack_i, wbm_dat_i,
        input  cmd_ready, rsp_valid, rsp_err, rsp_rdata,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );
endinterface

// File: rtl/wbm_ctrl.sv
// Wishbone initiator controller: turns one command into one 32-bit beat
// (narrow) or two 32-bit beats low-then-high (wide) separated by an idle
// gap cycle, with a per-beat ack timeout that ends the command with an error.
module wbm_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    wbm_ctrl_if.master   bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        GAP  = 3'd2,
        HI   = 3'd3,
        RESP = 3'd4
    } state_e;

    // Count value seen on the last allowed stb-high cycle without ack.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic        wide_q, wide_d;
    logic [31:0] base_q, base_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [63:0] rdata_q, rdata_d;

    logic        cyc_q;
    logic        stb_q;
    logic        wbwe_q;
    logic [3:0]  sel_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic        beat_d;

    // State and captured-command registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            wide_q  <= 1'b0;
            base_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the values from before this edge.
            state_q <= state_d;
            we_q    <= we_d;
            wide_q  <= wide_d;
            base_q  <= base_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state, command capture, timeout counting and read-data capture.
    always_comb begin
        // NOTE: hold-value defaults first so no path through the case leaves a signal unassigned (no latches).
        state_d = state_q;
        we_d    = we_q;
        wide_d  = wide_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_d = LO;
                    we_d    = bus.cmd_we;
                    wide_d  = bus.cmd_wide;
                    base_d  = bus.cmd_adr & (bus.cmd_wide ? ~32'h7 : ~32'h3);
                    wdata_d = bus.cmd_wdata;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            LO: begin
                if (bus.wbm_ack_i) begin
                    if (!we_q) rdata_d = {32'h0, bus.wbm_dat_i};
                    state_d = wide_q ? GAP : RESP;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            GAP: begin
                state_d = HI;
                cnt_d   = '0;
            end
            HI: begin
                if (bus.wbm_ack_i) begin
                    if (!we_q) rdata_d[63:32] = bus.wbm_dat_i;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign beat_d = (state_d == LO) || (state_d == HI);

    // Registered Wishbone outputs, loaded from the state being entered.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cyc_q  <= 1'b0;
            stb_q  <= 1'b0;
            wbwe_q <= 1'b0;
            sel_q  <= '0;
            adr_q  <= '0;
            dat_q  <= '0;
        end else begin
            cyc_q  <= beat_d;
            stb_q  <= beat_d;
            wbwe_q <= beat_d & we_d;
            sel_q  <= beat_d ? 4'hF : 4'h0;
            if (state_d == LO) begin
                adr_q <= base_d;
                dat_q <= wdata_d[31:0];
            end else if (state_d == HI) begin
                adr_q <= base_d + 32'd4;
                dat_q <= wdata_d[63:32];
            end else begin
                adr_q <= '0;
                dat_q <= '0;
            end
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_err   = (state_q == RESP) & err_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.wbm_cyc_o = cyc_q;
    assign bus.wbm_stb_o = stb_q;
    assign bus.wbm_we_o  = wbwe_q;
    assign bus.wbm_sel_o = sel_q;
    assign bus.wbm_adr_o = adr_q;
    assign bus.wbm_dat_o = dat_q;

endmodule

// File: tb/tb_wbm_ctrl.sv
// Directed bench for wbm_ctrl: inputs change and outputs are sampled on the
// falling clock edge; the Wishbone target is played step by step below.
module tb_wbm_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    wbm_ctrl_if bus ();

    wbm_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present a command for one edge, then withdraw it.
    task automatic issue(input logic we, input logic wide, input logic [31:0] adr, input logic [63:0] wdata);
        bus.cmd_we    = we;
        bus.cmd_wide  = wide;
        bus.cmd_adr   = adr;
        bus.cmd_wdata = wdata;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        int n;
        int hits;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_wide  = 1'b0;
        bus.cmd_adr   = '0;
        bus.cmd_wdata = '0;
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_cyc", bus.wbm_cyc_o, 0);
        check("rst_stb", bus.wbm_stb_o, 0);
        check("rst_we", bus.wbm_we_o, 0);
        check("rst_sel", bus.wbm_sel_o, 0);
        check("rst_adr", bus.wbm_adr_o, 0);
        check("rst_dat", bus.wbm_dat_o, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_rdata", bus.rsp_rdata, 0);

        // Narrow write, 1-cycle responder
        issue(1'b1, 1'b0, 32'h3000_0004, 64'h1);
        check("nw_stb", bus.wbm_stb_o, 1);
        check("nw_cyc", bus.wbm_cyc_o, 1);
        check("nw_we", bus.wbm_we_o, 1);
        check("nw_sel", bus.wbm_sel_o, 4'hF);
        check("nw_adr", bus.wbm_adr_o, 32'h3000_0004);
        check("nw_dat", bus.wbm_dat_o, 32'h1);
        check("nw_ready_busy", bus.cmd_ready, 0);
        check("nw_rsp_early", bus.rsp_valid, 0);
        tick();
        check("nw_stb_wait", bus.wbm_stb_o, 1);
        bus.wbm_ack_i = 1'b1;
        tick();
        bus.wbm_ack_i = 1'b0;
        check("nw_stb_drop", bus.wbm_stb_o, 0);
        check("nw_cyc_drop", bus.wbm_cyc_o, 0);
        check("nw_rsp_valid", bus.rsp_valid, 1);
        check("nw_rsp_err", bus.rsp_err, 0);
        tick();
        check("nw_rsp_pulse", bus.rsp_valid, 0);
        check("nw_ready_back", bus.cmd_ready, 1);

        // Wide write: low beat, gap, high beat
        issue(1'b1, 1'b1, 32'h3001_0018, 64'h0000_00AB_1234_5678);
        check("ww_lo_adr", bus.wbm_adr_o, 32'h3001_0018);
        check("ww_lo_dat", bus.wbm_dat_o, 32'h1234_5678);
        check("ww_lo_stb", bus.wbm_stb_o, 1);
        tick();
        bus.wbm_ack_i = 1'b1;
        tick();
        bus.wbm_ack_i = 1'b0;
        check("ww_gap_stb", bus.wbm_stb_o, 0);
        check("ww_gap_cyc", bus.wbm_cyc_o, 0);
        check("ww_gap_rsp", bus.rsp_valid, 0);
        tick();
        check("ww_hi_stb", bus.wbm_stb_o, 1);
        check("ww_hi_adr", bus.wbm_adr_o, 32'h3001_001C);
        check("ww_hi_dat", bus.wbm_dat_o, 32'h0000_00AB);
        check("ww_hi_we", bus.wbm_we_o, 1);
        tick();
        bus.wbm_ack_i = 1'b1;
        tick();
        bus.wbm_ack_i = 1'b0;
        check("ww_rsp_valid", bus.rsp_valid, 1);
        check("ww_rsp_err", bus.rsp_err, 0);
        check("ww_stb_end", bus.wbm_stb_o, 0);
        tick();

        // Wide read with cmd_valid held high throughout and a spurious ack in GAP
        bus.cmd_we    = 1'b0;
        bus.cmd_wide  = 1'b1;
        bus.cmd_adr   = 32'h3003_0008;
        bus.cmd_wdata = '0;
        bus.cmd_valid = 1'b1;
        tick();
        check("wr_lo_adr", bus.wbm_adr_o, 32'h3003_0008);
        check("wr_lo_we", bus.wbm_we_o, 0);
        bus.cmd_we    = 1'b1;
        bus.cmd_wide  = 1'b0;
        bus.cmd_adr   = 32'h3004_000B;
        bus.cmd_wdata = 64'h55;
        tick();
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = 32'hDEAD_BEEF;
        tick();
        check("wr_gap_stb", bus.wbm_stb_o, 0);
        check("wr_gap_ready", bus.cmd_ready, 0);
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = 32'h1234_5678;
        tick();
        bus.wbm_ack_i = 1'b0;
        check("wr_hi_stb", bus.wbm_stb_o, 1);
        check("wr_hi_adr", bus.wbm_adr_o, 32'h3003_000C);
        check("wr_spurious_rsp", bus.rsp_valid, 0);
        check("wr_lo_capture", bus.rsp_rdata, 64'h0000_0000_DEAD_BEEF);
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = 32'h0000_CAFE;
        tick();
        bus.wbm_ack_i = 1'b0;
        check("wr_rsp_valid", bus.rsp_valid, 1);
        check("wr_rsp_err", bus.rsp_err, 0);
        check("wr_rdata", bus.rsp_rdata, 64'h0000_CAFE_DEAD_BEEF);
        tick();
        check("wr_idle_ready", bus.cmd_ready, 1);
        check("wr_idle_stb", bus.wbm_stb_o, 0);
        tick();
        bus.cmd_valid = 1'b0;
        // The held command is taken only once back in IDLE, narrow-aligned.
        check("held_stb", bus.wbm_stb_o, 1);
        check("held_adr", bus.wbm_adr_o, 32'h3004_0008);
        check("held_dat", bus.wbm_dat_o, 32'h55);
        check("held_we", bus.wbm_we_o, 1);
        tick();
        bus.wbm_ack_i = 1'b1;
        tick();
        bus.wbm_ack_i = 1'b0;
        check("held_rsp_valid", bus.rsp_valid, 1);
        check("held_rdata_kept", bus.rsp_rdata, 64'h0000_CAFE_DEAD_BEEF);
        tick();

        // Narrow read, target never acks: stb high exactly 16 cycles
        issue(1'b0, 1'b0, 32'h3005_0000, 64'h0);
        n = 0;
        while (bus.wbm_stb_o === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check("to_stb_cycles", 64'(n), 64'd16);
        check("to_rsp_valid", bus.rsp_valid, 1);
        check("to_rsp_err", bus.rsp_err, 1);
        tick();
        check("to_err_cleared", bus.rsp_err, 0);

        // Wide read timing out in LO issues no HI beat
        issue(1'b0, 1'b1, 32'h3006_0000, 64'h0);
        n = 0;
        while (bus.wbm_stb_o === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check("tow_stb_cycles", 64'(n), 64'd16);
        check("tow_rsp_err", bus.rsp_err, 1);
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.wbm_stb_o !== 1'b0) hits++;
        end
        check("tow_no_hi_beat", 64'(hits), 64'd0);

        // Ack on the final allowed cycle wins over timeout
        issue(1'b0, 1'b0, 32'h3007_0000, 64'h0);
        for (int i = 0; i < 15; i++) tick();
        check("last_stb", bus.wbm_stb_o, 1);
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = 32'h0000_1111;
        tick();
        bus.wbm_ack_i = 1'b0;
        check("last_rsp_valid", bus.rsp_valid, 1);
        check("last_rsp_err", bus.rsp_err, 0);
        check("last_rdata", bus.rsp_rdata, 64'h0000_0000_0000_1111);
        tick();

        // Reset while stb high in HI
        issue(1'b1, 1'b1, 32'h3008_0000, 64'h2222_2222_1111_1111);
        tick();
        bus.wbm_ack_i = 1'b1;
        tick();
        bus.wbm_ack_i = 1'b0;
        tick();
        check("mid_hi_stb", bus.wbm_stb_o, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_stb", bus.wbm_stb_o, 0);
        check("mid_rst_cyc", bus.wbm_cyc_o, 0);
        tick();
        rst = 1'b0;
        hits = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.rsp_valid !== 1'b0) hits++;
            tick();
        end
        check("mid_no_rsp", 64'(hits), 64'd0);
        check("mid_ready", bus.cmd_ready, 1);
        issue(1'b1, 1'b0, 32'h3009_0010, 64'h77);
        check("post_adr", bus.wbm_adr_o, 32'h3009_0010);
        check("post_dat", bus.wbm_dat_o, 32'h77);
        tick();
        bus.wbm_ack_i = 1'b1;
        tick();
        bus.wbm_ack_i = 1'b0;
        check("post_rsp_valid", bus.rsp_valid, 1);
        check("post_rsp_err", bus.rsp_err, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
